// File: rtl/prog_loader.sv
// prog_loader: receives a framed program (header N, N instruction bytes,
// checksum byte) over a valid/ready byte stream and writes it into a
// 32 x 8 instruction memory, holding the CPU until a load has been verified.
//
// Ports:
//   clk_i, rst_i        single clock, synchronous active-high reset
//   start_i             one-cycle pulse requesting a new load (ignored while busy)
//   in_valid_i/in_data_i/in_ready_o   upstream byte handshake
//   im_we_o/im_addr_o/im_wdata_o      instruction-memory write port
//   cpu_hold_o          1 holds the CPU at PC 0; released only after a good load
//   busy_o/done_o/error_o             load status (done/error are held levels)
module prog_loader (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       im_we_o,
  output logic [4:0] im_addr_o,
  output logic [7:0] im_wdata_o,
  output logic       cpu_hold_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HEADER = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  logic [2:0] state_q, state_d;
  logic [5:0] n_q, n_d;        // instruction count from the header
  logic [5:0] cnt_q, cnt_d;    // index of the next instruction byte
  logic [7:0] acc_q, acc_d;    // running mod-256 sum of instruction bytes
  logic       we_q, we_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

  logic busy;
  logic accept;
  logic hdr_ok;

  assign busy   = (state_q == S_HEADER) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign accept = busy && in_valid_i;
  assign hdr_ok = (in_data_i != 8'd0) && (in_data_i <= 8'd32);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_HEADER;
        end
      end

      S_HEADER: begin
        if (accept) begin
          // Only the low 6 bits matter: an out-of-range header never
          // reaches DATA, so the truncated value is never used.
          n_d     = in_data_i[5:0];
          cnt_d   = 6'd0;
          acc_d   = 8'd0;
          state_d = hdr_ok ? S_DATA : S_ERROR;
        end
      end

      S_DATA: begin
        if (accept) begin
          // The write is registered, so it appears the cycle after acceptance.
          we_d    = 1'b1;
          addr_d  = cnt_q[4:0];
          wdata_d = in_data_i;
          acc_d   = acc_q + in_data_i;
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == (n_q - 6'd1)) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (accept) begin
          state_d = (in_data_i == acc_q) ? S_DONE : S_ERROR;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Reset wins over everything, which also drops a write whose byte was
  // accepted in the reset cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      n_q     <= 6'd0;
      cnt_q   <= 6'd0;
      acc_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 5'd0;
      wdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready_o = busy;
  assign busy_o     = busy;
  assign im_we_o    = we_q;
  assign im_addr_o  = addr_q;
  assign im_wdata_o = wdata_q;
  // DONE is only reachable after CHECK, so the hold is released at least one
  // cycle after the final instruction write.
  assign cpu_hold_o = (state_q != S_DONE);
  assign done_o     = (state_q == S_DONE);
  assign error_o    = (state_q == S_ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader.
// Status vector compared below is {in_ready, im_we, busy, done, error, cpu_hold}.
// Writes seen on the memory port are logged as {addr, data} for comparison.
module tb_prog_loader;

  logic       clk_i;
  logic       rst_i;
  logic       start_i;
  logic       in_valid_i;
  logic [7:0] in_data_i;
  logic       in_ready_o;
  logic       im_we_o;
  logic [4:0] im_addr_o;
  logic [7:0] im_wdata_o;
  logic       cpu_hold_o;
  logic       busy_o;
  logic       done_o;
  logic       error_o;

  int total = 0;
  int bad   = 0;

  logic [12:0] wr_q[$];

  localparam logic [5:0] ST_IDLE   = 6'b000001;
  localparam logic [5:0] ST_HEADER = 6'b101001;
  localparam logic [5:0] ST_DATA   = 6'b101001;
  localparam logic [5:0] ST_DATAWR = 6'b111001;
  localparam logic [5:0] ST_CHKWR  = 6'b111001;
  localparam logic [5:0] ST_DONE   = 6'b000100;
  localparam logic [5:0] ST_ERROR  = 6'b000011;

  wire [5:0] status = {in_ready_o, im_we_o, busy_o, done_o, error_o, cpu_hold_o};

  prog_loader dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
    .im_we_o    (im_we_o),
    .im_addr_o  (im_addr_o),
    .im_wdata_o (im_wdata_o),
    .cpu_hold_o (cpu_hold_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .error_o    (error_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (im_we_o) wr_q.push_back({im_addr_o, im_wdata_o});
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    total++;
    if (in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL in_ready_before_byte: got %b want 1 (byte %h)", in_ready_o, b);
    end
    in_valid_i = 1'b1;
    in_data_i  = b;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i      = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = 8'h55;
    start_i    = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if (status !== ST_IDLE) begin
      bad++; $display("FAIL reset_status: got %b want %b", status, ST_IDLE);
    end
    total++;
    if ({im_addr_o, im_wdata_o} !== 13'd0) begin
      bad++; $display("FAIL reset_addr_data: got %h/%h want 0/0", im_addr_o, im_wdata_o);
    end
    rst_i = 1'b0; in_valid_i = 1'b0; start_i = 1'b0;
    @(posedge clk_i); #1;
    total++;
    if (status !== ST_IDLE) begin
      bad++; $display("FAIL idle_after_reset: got %b want %b", status, ST_IDLE);
    end
  endtask

  task automatic test_nominal();
    wr_q.delete();
    pulse_start();
    total++;
    if (status !== ST_HEADER) begin
      bad++; $display("FAIL nominal_header: got %b want %b", status, ST_HEADER);
    end
    send_byte(8'h03);
    send_byte(8'h21);
    send_byte(8'h4A);
    send_byte(8'h85);
    total++;
    if (status !== ST_CHKWR) begin
      bad++; $display("FAIL nominal_check_state: got %b want %b", status, ST_CHKWR);
    end
    // 21 + 4A + 85 = F0 (mod 256)
    send_byte(8'hF0);
    total++;
    if (status !== ST_DONE) begin
      bad++; $display("FAIL nominal_done: got %b want %b", status, ST_DONE);
    end
    total++;
    if ({im_addr_o, im_wdata_o} !== {5'd2, 8'h85}) begin
      bad++; $display("FAIL nominal_hold_addr_data: got %h/%h want 02/85", im_addr_o, im_wdata_o);
    end
    total++;
    if (wr_q.size() !== 3) begin
      bad++; $display("FAIL nominal_write_count: got %0d want 3", wr_q.size());
    end else begin
      total++;
      if (wr_q[0] !== {5'd0, 8'h21} || wr_q[1] !== {5'd1, 8'h4A} || wr_q[2] !== {5'd2, 8'h85}) begin
        bad++; $display("FAIL nominal_writes: got %h %h %h want 0021 014a 0285", wr_q[0], wr_q[1], wr_q[2]);
      end
    end
  endtask

  task automatic test_wrong_sum();
    // E8 differs from the true sum F0, and starting from DONE must re-arm.
    wr_q.delete();
    pulse_start();
    total++;
    if (status !== ST_HEADER) begin
      bad++; $display("FAIL wrongsum_restart: got %b want %b", status, ST_HEADER);
    end
    send_byte(8'h03); send_byte(8'h21); send_byte(8'h4A); send_byte(8'h85);
    send_byte(8'hE8);
    total++;
    if (status !== ST_ERROR) begin
      bad++; $display("FAIL wrongsum_error: got %b want %b", status, ST_ERROR);
    end
  endtask

  task automatic test_bad_checksum();
    wr_q.delete();
    pulse_start();
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
    total++;
    if (status !== ST_ERROR) begin
      bad++; $display("FAIL badsum_error: got %b want %b", status, ST_ERROR);
    end
    total++;
    if (wr_q.size() !== 2) begin
      bad++; $display("FAIL badsum_write_count: got %0d want 2", wr_q.size());
    end else begin
      total++;
      if (wr_q[0] !== {5'd0, 8'h10} || wr_q[1] !== {5'd1, 8'h20}) begin
        bad++; $display("FAIL badsum_writes: got %h %h want 0010 0120", wr_q[0], wr_q[1]);
      end
    end
  endtask

  task automatic test_bad_header();
    logic [7:0] hdrs [3];
    hdrs[0] = 8'h00; hdrs[1] = 8'h21; hdrs[2] = 8'hFF;
    for (int h = 0; h < 3; h++) begin
      wr_q.delete();
      pulse_start();
      send_byte(hdrs[h]);
      total++;
      if (status !== ST_ERROR) begin
        bad++; $display("FAIL badhdr_error_%h: got %b want %b", hdrs[h], status, ST_ERROR);
      end
      @(posedge clk_i); #1;
      total++;
      if (wr_q.size() !== 0) begin
        bad++; $display("FAIL badhdr_no_write_%h: got %0d writes want 0", hdrs[h], wr_q.size());
      end
    end
  endtask

  task automatic test_full_stall();
    logic [7:0] d;
    logic [7:0] sum;
    int         errs;
    wr_q.delete();
    sum  = 8'd0;
    errs = 0;
    pulse_start();
    send_byte(8'd32);
    for (int i = 0; i < 32; i++) begin
      d = 8'(i * 37 + 5);
      while ($urandom_range(0, 1) == 1) begin
        in_valid_i = 1'b0;
        in_data_i  = 8'hXX;
        @(posedge clk_i); #1;
        total++;
        if (status !== ST_DATA) begin
          bad++; $display("FAIL stall_state_%0d: got %b want %b", i, status, ST_DATA);
        end
      end
      send_byte(d);
      sum = sum + d;
    end
    total++;
    if (status !== ST_CHKWR) begin
      bad++; $display("FAIL full_check_state: got %b want %b", status, ST_CHKWR);
    end
    send_byte(sum);
    total++;
    if (status !== ST_DONE) begin
      bad++; $display("FAIL full_done: got %b want %b", status, ST_DONE);
    end
    total++;
    if (wr_q.size() !== 32) begin
      bad++; $display("FAIL full_write_count: got %0d want 32", wr_q.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (wr_q[i] !== {5'(i), 8'(i * 37 + 5)}) errs++;
      end
      total++;
      if (errs !== 0) begin
        bad++; $display("FAIL full_writes: got %0d wrong entries want 0", errs);
      end
    end
  endtask

  task automatic test_reset_mid();
    wr_q.delete();
    pulse_start();
    send_byte(8'h04); send_byte(8'hA1); send_byte(8'hB2);
    // Third data byte offered in the reset cycle must never be written.
    rst_i      = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = 8'hC3;
    @(posedge clk_i); #1;
    total++;
    if (status !== ST_IDLE || {im_addr_o, im_wdata_o} !== 13'd0) begin
      bad++; $display("FAIL midreset_outputs: got %b %h/%h want %b 00/00", status, im_addr_o, im_wdata_o, ST_IDLE);
    end
    rst_i = 1'b0; in_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if (wr_q.size() !== 2 || status !== ST_IDLE) begin
      bad++; $display("FAIL midreset_no_more_writes: got %0d writes status %b want 2 %b", wr_q.size(), status, ST_IDLE);
    end
    pulse_start();
    send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5A);
    total++;
    if (status !== ST_DONE || wr_q.size() !== 3) begin
      bad++; $display("FAIL midreset_reload: got %b %0d writes want %b 3", status, wr_q.size(), ST_DONE);
    end else begin
      total++;
      if (wr_q[2] !== {5'd0, 8'h5A}) begin
        bad++; $display("FAIL midreset_reload_write: got %h want 005a", wr_q[2]);
      end
    end
  endtask

  task automatic test_start_busy();
    wr_q.delete();
    pulse_start();
    send_byte(8'h02);
    start_i = 1'b1;
    send_byte(8'h11);
    start_i = 1'b0;
    total++;
    if (status !== ST_DATAWR) begin
      bad++; $display("FAIL busy_start_with_byte: got %b want %b", status, ST_DATAWR);
    end
    pulse_start();
    total++;
    if (status !== ST_DATA) begin
      bad++; $display("FAIL busy_start_alone: got %b want %b", status, ST_DATA);
    end
    send_byte(8'h22);
    send_byte(8'h33);
    total++;
    if (status !== ST_DONE || wr_q.size() !== 2) begin
      bad++; $display("FAIL busy_load_done: got %b %0d writes want %b 2", status, wr_q.size(), ST_DONE);
    end else begin
      total++;
      if (wr_q[0] !== {5'd0, 8'h11} || wr_q[1] !== {5'd1, 8'h22}) begin
        bad++; $display("FAIL busy_writes: got %h %h want 0011 0122", wr_q[0], wr_q[1]);
      end
    end
    pulse_start();
    total++;
    if (status !== ST_HEADER) begin
      bad++; $display("FAIL start_from_done: got %b want %b", status, ST_HEADER);
    end
    send_byte(8'h01); send_byte(8'h07); send_byte(8'h07);
    total++;
    if (status !== ST_DONE) begin
      bad++; $display("FAIL final_load_done: got %b want %b", status, ST_DONE);
    end
  endtask

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = 8'h00;
    test_reset();
    test_nominal();
    test_wrong_sum();
    test_bad_checksum();
    test_bad_header();
    test_full_stall();
    test_reset_mid();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
